// File: rtl/mrx_hop_pkg.sv
// Shared hop-plan constants and controller state encoding for the narrowband
// hopping link; the transmit controller uses the same values.
package mrx_hop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC_MEAS = 3'd1,
    ST_ARMED     = 3'd2,
    ST_HOP_RX    = 3'd3,
    ST_HOP_GAP   = 3'd4
  } mrx_state_e;

  localparam logic [23:0] MRX_HOP_START_PH_INC = 24'hC00000;
  localparam logic [23:0] MRX_HOP_DPH_INC      = 24'h020000;

endpackage

// File: rtl/mrx_hop_sync_ctrl_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a history flop
// used to report one-cycle rise/fall indications.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~hist_q;
  assign fall  = ~s2_q & hist_q;

endmodule

// File: rtl/mrx_hop_sync_ctrl.sv
// Receive-side hop sequencer: tracks the transmitter's sync and hop-TX levels
// and steps the local phase increment in lockstep, gating the rx datapath.
module mrx_hop_sync_ctrl
  import mrx_hop_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned NHOP_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned NUM_HOPS    = 64,
  parameter logic [PHASE_WIDTH-1:0] HOP_START_PH_INC = PHASE_WIDTH'(MRX_HOP_START_PH_INC),
  parameter logic [PHASE_WIDTH-1:0] HOP_DPH_INC      = PHASE_WIDTH'(MRX_HOP_DPH_INC),
  parameter int unsigned SYNC_MIN_LEN = 8192,
  parameter int unsigned GAP_TIMEOUT  = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_in,
  input  logic                   tx_in,
  output logic                   rx_valid,
  output logic [PHASE_WIDTH-1:0] hop_phase_inc,
  output logic [NHOP_WIDTH-1:0]  nhop,
  output logic                   hop_start,
  output logic                   hop_end,
  output logic                   frame_done,
  output logic                   sync_err,
  output logic [2:0]             mrx_state
);

  localparam logic [NHOP_WIDTH-1:0] LAST_HOP    = NHOP_WIDTH'(NUM_HOPS - 1);
  localparam logic [CNT_WIDTH-1:0]  SYNC_MIN_M1 = CNT_WIDTH'(SYNC_MIN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LIMIT   = CNT_WIDTH'(GAP_TIMEOUT);

  logic sync_lvl, sync_rise, sync_fall;
  logic tx_lvl_unused, tx_rise, tx_fall;

  sync_edge_det u_sync_det (
    .clk   (clk),
    .reset (reset),
    .din   (sync_in),
    .level (sync_lvl),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  sync_edge_det u_tx_det (
    .clk   (clk),
    .reset (reset),
    .din   (tx_in),
    .level (tx_lvl_unused),
    .rise  (tx_rise),
    .fall  (tx_fall)
  );

  mrx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   sync_cnt_q, sync_cnt_d;
  logic [CNT_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NHOP_WIDTH-1:0]  nhop_q, nhop_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic evt_start_q, evt_start_d;
  logic evt_end_q, evt_end_d;
  logic evt_frame_q, evt_frame_d;
  logic evt_err_q, evt_err_d;

  // Output stage registers (one cycle behind the FSM)
  logic                   rx_valid_q, rx_valid_d;
  logic                   hop_start_q, hop_start_d;
  logic                   hop_end_q, hop_end_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sync_err_q, sync_err_d;
  logic [NHOP_WIDTH-1:0]  nhop_o_q, nhop_o_d;
  logic [PHASE_WIDTH-1:0] phase_o_q, phase_o_d;
  logic [2:0]             state_o_q, state_o_d;

  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    nhop_d      = nhop_q;
    phase_d     = phase_q;
    evt_start_d = 1'b0;
    evt_end_d   = 1'b0;
    evt_frame_d = 1'b0;
    evt_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_rise) begin
          state_d    = ST_SYNC_MEAS;
          sync_cnt_d = '0;
        end
      end

      ST_SYNC_MEAS: begin
        if (sync_fall) begin
          if (sync_cnt_q >= SYNC_MIN_M1) begin
            state_d   = ST_ARMED;
            nhop_d    = '0;
            phase_d   = HOP_START_PH_INC;
            gap_cnt_d = '0;
          end else begin
            state_d   = ST_IDLE;
            evt_err_d = 1'b1;
          end
        end else if (sync_lvl && (sync_cnt_q != '1)) begin
          sync_cnt_d = sync_cnt_q + CNT_WIDTH'(1);
        end
      end

      ST_ARMED, ST_HOP_GAP: begin
        if (sync_rise) begin
          state_d    = ST_SYNC_MEAS;
          sync_cnt_d = '0;
          nhop_d     = '0;
          phase_d    = HOP_START_PH_INC;
          evt_err_d  = 1'b1;
        end else if (gap_cnt_q == GAP_LIMIT) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
          nhop_d    = '0;
          phase_d   = HOP_START_PH_INC;
          evt_err_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_WIDTH'(1);
          // A still-high sync level masks tx edges
          if (!sync_lvl && tx_rise) begin
            state_d     = ST_HOP_RX;
            gap_cnt_d   = '0;
            evt_start_d = 1'b1;
          end
        end
      end

      ST_HOP_RX: begin
        if (sync_rise) begin
          state_d    = ST_SYNC_MEAS;
          sync_cnt_d = '0;
          nhop_d     = '0;
          phase_d    = HOP_START_PH_INC;
          evt_err_d  = 1'b1;
        end else if (!sync_lvl && tx_fall) begin
          evt_end_d = 1'b1;
          if (nhop_q < LAST_HOP) begin
            state_d   = ST_HOP_GAP;
            nhop_d    = nhop_q + NHOP_WIDTH'(1);
            phase_d   = phase_q + HOP_DPH_INC;
            gap_cnt_d = '0;
          end else begin
            state_d     = ST_IDLE;
            nhop_d      = '0;
            phase_d     = HOP_START_PH_INC;
            evt_frame_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d   = (state_q == ST_HOP_RX);
    hop_start_d  = evt_start_q;
    hop_end_d    = evt_end_q;
    frame_done_d = evt_frame_q;
    sync_err_d   = evt_err_q;
    nhop_o_d     = nhop_q;
    phase_o_d    = phase_q;
    state_o_d    = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sync_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      nhop_q       <= '0;
      phase_q      <= HOP_START_PH_INC;
      evt_start_q  <= 1'b0;
      evt_end_q    <= 1'b0;
      evt_frame_q  <= 1'b0;
      evt_err_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      hop_start_q  <= 1'b0;
      hop_end_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      nhop_o_q     <= '0;
      phase_o_q    <= HOP_START_PH_INC;
      state_o_q    <= '0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      nhop_q       <= nhop_d;
      phase_q      <= phase_d;
      evt_start_q  <= evt_start_d;
      evt_end_q    <= evt_end_d;
      evt_frame_q  <= evt_frame_d;
      evt_err_q    <= evt_err_d;
      rx_valid_q   <= rx_valid_d;
      hop_start_q  <= hop_start_d;
      hop_end_q    <= hop_end_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      nhop_o_q     <= nhop_o_d;
      phase_o_q    <= phase_o_d;
      state_o_q    <= state_o_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign hop_phase_inc = phase_o_q;
  assign nhop          = nhop_o_q;
  assign hop_start     = hop_start_q;
  assign hop_end       = hop_end_q;
  assign frame_done    = frame_done_q;
  assign sync_err      = sync_err_q;
  assign mrx_state     = state_o_q;

endmodule

// File: tb/tb_mrx_hop_sync_ctrl.sv
// Directed bench for mrx_hop_sync_ctrl with a 4-hop frame and short sync/gap limits.
module tb_mrx_hop_sync_ctrl;

  logic        clk, reset, sync_in, tx_in;
  logic        rx_valid, hop_start, hop_end, frame_done, sync_err;
  logic [23:0] hop_phase_inc;
  logic [7:0]  nhop;
  logic [2:0]  mrx_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  mrx_hop_sync_ctrl #(
    .PHASE_WIDTH      (24),
    .NHOP_WIDTH       (8),
    .CNT_WIDTH        (24),
    .NUM_HOPS         (4),
    .HOP_START_PH_INC (24'hFFFF00),
    .HOP_DPH_INC      (24'h000100),
    .SYNC_MIN_LEN     (16),
    .GAP_TIMEOUT      (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sync_in       (sync_in),
    .tx_in         (tx_in),
    .rx_valid      (rx_valid),
    .hop_phase_inc (hop_phase_inc),
    .nhop          (nhop),
    .hop_start     (hop_start),
    .hop_end       (hop_end),
    .frame_done    (frame_done),
    .sync_err      (sync_err),
    .mrx_state     (mrx_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event monitor sampled on the falling edge
  int n_hs = 0, n_he = 0, n_fd = 0, n_fd_he = 0, n_err = 0, n_rxv = 0;
  int n_runs = 0, run_len = 0, n_unstable = 0;
  int rec_nhop[64];
  logic [23:0] rec_ph[64];
  int rec_len[64];
  logic prev_rxv = 1'b0;
  logic [7:0] prev_nhop;
  logic [23:0] prev_ph;

  always @(negedge clk) begin
    if (hop_start === 1'b1) begin
      if (n_hs < 64) begin
        rec_nhop[n_hs] = int'(nhop);
        rec_ph[n_hs]   = hop_phase_inc;
      end
      n_hs++;
    end
    if (hop_end === 1'b1) n_he++;
    if (frame_done === 1'b1) begin
      n_fd++;
      if (hop_end === 1'b1) n_fd_he++;
    end
    if (sync_err === 1'b1) n_err++;
    if (rx_valid === 1'b1) begin
      n_rxv++;
      run_len++;
      if (prev_rxv && (nhop !== prev_nhop || hop_phase_inc !== prev_ph)) n_unstable++;
    end else if (prev_rxv) begin
      if (n_runs < 64) rec_len[n_runs] = run_len;
      n_runs++;
      run_len = 0;
    end
    prev_rxv  = (rx_valid === 1'b1);
    prev_nhop = nhop;
    prev_ph   = hop_phase_inc;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_pulse(input int len);
    sync_in = 1'b1;
    clk_n(len);
    sync_in = 1'b0;
  endtask

  task automatic frame_hops(input int hops);
    for (int h = 0; h < hops; h++) begin
      tx_in = 1'b0;
      clk_n(10);
      tx_in = 1'b1;
      clk_n(50);
    end
    tx_in = 1'b0;
    clk_n(10);
  endtask

  task automatic test_reset;
    int hs0, err0, rxv0;
    reset = 1'b1; sync_in = 1'b0; tx_in = 1'b0;
    clk_n(3);
    total_cnt++;
    if (mrx_state !== 3'd0 || rx_valid !== 1'b0 || nhop !== 8'd0 || hop_phase_inc !== 24'hFFFF00)
      $display("FAIL reset_vals: state=%0d rxv=%b nhop=%0d ph=%h exp 0/0/0/ffff00",
               mrx_state, rx_valid, nhop, hop_phase_inc);
    else pass_cnt++;
    total_cnt++;
    if ({hop_start, hop_end, frame_done, sync_err} !== 4'b0000)
      $display("FAIL reset_pulses: got %b expected 0000", {hop_start, hop_end, frame_done, sync_err});
    else pass_cnt++;
    reset = 1'b0;
    hs0 = n_hs; err0 = n_err; rxv0 = n_rxv;
    for (int i = 0; i < 4; i++) begin
      clk_n(5); tx_in = 1'b1;
      clk_n(5); tx_in = 1'b0;
    end
    clk_n(8);
    total_cnt++;
    if (mrx_state !== 3'd0) $display("FAIL idle_tx_state: got %0d expected 0", mrx_state);
    else pass_cnt++;
    total_cnt++;
    if (n_hs - hs0 != 0 || n_err - err0 != 0 || n_rxv - rxv0 != 0)
      $display("FAIL idle_tx_quiet: hs=%0d err=%0d rxv=%0d expected 0/0/0",
               n_hs - hs0, n_err - err0, n_rxv - rxv0);
    else pass_cnt++;
  endtask

  task automatic test_frame;
    logic [23:0] exp_ph[4];
    int hs0, he0, fd0, fdhe0, run0, uns0;
    exp_ph[0] = 24'hFFFF00; exp_ph[1] = 24'h000000;
    exp_ph[2] = 24'h000100; exp_ph[3] = 24'h000200;
    hs0 = n_hs; he0 = n_he; fd0 = n_fd; fdhe0 = n_fd_he; run0 = n_runs; uns0 = n_unstable;
    sync_pulse(20);
    for (int h = 0; h < 4; h++) begin
      tx_in = 1'b0;
      clk_n(h == 0 ? 10 : 6);
      tx_in = 1'b1;
      clk_n(3);
      total_cnt++;
      if (rx_valid !== 1'b0) $display("FAIL frame_latency_early h%0d: rxv=%b expected 0", h, rx_valid);
      else pass_cnt++;
      clk_n(1);
      total_cnt++;
      if (rx_valid !== 1'b1 || hop_start !== 1'b1 || mrx_state !== 3'd3)
        $display("FAIL frame_start h%0d: rxv=%b hs=%b state=%0d expected 1/1/3", h, rx_valid, hop_start, mrx_state);
      else pass_cnt++;
      total_cnt++;
      if (nhop !== 8'(h) || hop_phase_inc !== exp_ph[h])
        $display("FAIL frame_hop h%0d: nhop=%0d ph=%h expected %0d/%h", h, nhop, hop_phase_inc, h, exp_ph[h]);
      else pass_cnt++;
      clk_n(46);
      tx_in = 1'b0;
      clk_n(4);
      total_cnt++;
      if (hop_end !== 1'b1 || frame_done !== (h == 3) || rx_valid !== 1'b0)
        $display("FAIL frame_end h%0d: he=%b fd=%b rxv=%b expected 1/%0d/0", h, hop_end, frame_done, rx_valid, h == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (mrx_state !== 3'd0 || nhop !== 8'd0 || hop_phase_inc !== 24'hFFFF00)
      $display("FAIL frame_idle: state=%0d nhop=%0d ph=%h expected 0/0/ffff00", mrx_state, nhop, hop_phase_inc);
    else pass_cnt++;
    clk_n(5);
    total_cnt++;
    if (n_hs - hs0 != 4 || n_he - he0 != 4 || n_fd - fd0 != 1 || n_fd_he - fdhe0 != 1)
      $display("FAIL frame_counts: hs=%0d he=%0d fd=%0d fd_he=%0d expected 4/4/1/1",
               n_hs - hs0, n_he - he0, n_fd - fd0, n_fd_he - fdhe0);
    else pass_cnt++;
    for (int r = 0; r < 4; r++) begin
      total_cnt++;
      if (rec_len[run0 + r] != 50) $display("FAIL frame_rxv_len r%0d: got %0d expected 50", r, rec_len[run0 + r]);
      else pass_cnt++;
    end
    total_cnt++;
    if (n_unstable - uns0 != 0) $display("FAIL frame_stable: got %0d changes expected 0", n_unstable - uns0);
    else pass_cnt++;
  endtask

  task automatic test_short_sync;
    int hs0, err0, rxv0;
    hs0 = n_hs; err0 = n_err; rxv0 = n_rxv;
    sync_pulse(10);
    clk_n(4);
    total_cnt++;
    if (sync_err !== 1'b1 || mrx_state !== 3'd0)
      $display("FAIL short_sync_err: err=%b state=%0d expected 1/0", sync_err, mrx_state);
    else pass_cnt++;
    clk_n(5);
    tx_in = 1'b1; clk_n(20);
    tx_in = 1'b0; clk_n(10);
    total_cnt++;
    if (n_hs - hs0 != 0 || n_rxv - rxv0 != 0 || n_err - err0 != 1 || mrx_state !== 3'd0)
      $display("FAIL short_sync_ignore: hs=%0d rxv=%0d err=%0d state=%0d expected 0/0/1/0",
               n_hs - hs0, n_rxv - rxv0, n_err - err0, mrx_state);
    else pass_cnt++;
  endtask

  task automatic test_gap_timeout;
    int err0, hs0;
    err0 = n_err; hs0 = n_hs;
    sync_pulse(20);
    clk_n(104);
    total_cnt++;
    if (sync_err !== 1'b0 || mrx_state !== 3'd2)
      $display("FAIL gap_before_timeout: err=%b state=%0d expected 0/2", sync_err, mrx_state);
    else pass_cnt++;
    clk_n(1);
    total_cnt++;
    if (sync_err !== 1'b1 || mrx_state !== 3'd0)
      $display("FAIL gap_timeout: err=%b state=%0d expected 1/0", sync_err, mrx_state);
    else pass_cnt++;
    clk_n(15);
    total_cnt++;
    if (n_err - err0 != 1 || n_hs - hs0 != 0)
      $display("FAIL gap_counts: err=%0d hs=%0d expected 1/0", n_err - err0, n_hs - hs0);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int hs0, he0, fd0, err0, base;
    hs0 = n_hs; he0 = n_he; fd0 = n_fd; err0 = n_err;
    sync_pulse(20);
    frame_hops(2);
    tx_in = 1'b1;
    clk_n(20);
    sync_in = 1'b1;
    clk_n(3);
    total_cnt++;
    if (rx_valid !== 1'b1 || nhop !== 8'd2)
      $display("FAIL abort_pre: rxv=%b nhop=%0d expected 1/2", rx_valid, nhop);
    else pass_cnt++;
    clk_n(1);
    total_cnt++;
    if (rx_valid !== 1'b0 || sync_err !== 1'b1 || mrx_state !== 3'd1 || nhop !== 8'd0)
      $display("FAIL abort: rxv=%b err=%b state=%0d nhop=%0d expected 0/1/1/0",
               rx_valid, sync_err, mrx_state, nhop);
    else pass_cnt++;
    clk_n(16);
    tx_in = 1'b0;
    sync_in = 1'b0;
    base = n_hs;
    frame_hops(4);
    total_cnt++;
    if (n_hs - hs0 != 7 || n_he - he0 != 6 || n_fd - fd0 != 1 || n_err - err0 != 1)
      $display("FAIL abort_counts: hs=%0d he=%0d fd=%0d err=%0d expected 7/6/1/1",
               n_hs - hs0, n_he - he0, n_fd - fd0, n_err - err0);
    else pass_cnt++;
    total_cnt++;
    if (rec_nhop[base] != 0 || rec_nhop[base + 3] != 3 || rec_ph[base + 1] !== 24'h000000 ||
        rec_ph[base + 3] !== 24'h000200)
      $display("FAIL abort_refrm: n0=%0d n3=%0d ph1=%h ph3=%h expected 0/3/000000/000200",
               rec_nhop[base], rec_nhop[base + 3], rec_ph[base + 1], rec_ph[base + 3]);
    else pass_cnt++;
    total_cnt++;
    if (mrx_state !== 3'd0) $display("FAIL abort_idle: state=%0d expected 0", mrx_state);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int hs0, he0, fd0, err0;
    hs0 = n_hs; he0 = n_he; fd0 = n_fd; err0 = n_err;
    sync_pulse(20);
    frame_hops(1);
    tx_in = 1'b1;
    clk_n(20);
    total_cnt++;
    if (rx_valid !== 1'b1 || nhop !== 8'd1)
      $display("FAIL rstmid_pre: rxv=%b nhop=%0d expected 1/1", rx_valid, nhop);
    else pass_cnt++;
    reset = 1'b1;
    clk_n(1);
    total_cnt++;
    if (rx_valid !== 1'b0 || mrx_state !== 3'd0 || nhop !== 8'd0 || hop_phase_inc !== 24'hFFFF00)
      $display("FAIL rstmid_vals: rxv=%b state=%0d nhop=%0d ph=%h expected 0/0/0/ffff00",
               rx_valid, mrx_state, nhop, hop_phase_inc);
    else pass_cnt++;
    total_cnt++;
    if ({hop_start, hop_end, frame_done, sync_err} !== 4'b0000)
      $display("FAIL rstmid_pulses: got %b expected 0000", {hop_start, hop_end, frame_done, sync_err});
    else pass_cnt++;
    clk_n(2);
    tx_in = 1'b0;
    reset = 1'b0;
    clk_n(10);
    total_cnt++;
    if (n_hs - hs0 != 2 || n_he - he0 != 1 || n_fd - fd0 != 0 || n_err - err0 != 0 || mrx_state !== 3'd0)
      $display("FAIL rstmid_counts: hs=%0d he=%0d fd=%0d err=%0d state=%0d expected 2/1/0/0/0",
               n_hs - hs0, n_he - he0, n_fd - fd0, n_err - err0, mrx_state);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    clk_n(10);
    test_frame;
    clk_n(10);
    test_short_sync;
    clk_n(10);
    test_gap_timeout;
    clk_n(10);
    test_abort;
    clk_n(10);
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
